// File: rtl/uart_mem_loader.sv
// Host byte-command engine: halts/releases the CPU and burst-writes/reads memory over the UART byte streams.
// Optional XOR checksum byte after W/R responses when UMEM_LOADER_CSUM_EN is defined.
module uart_mem_loader #(
  parameter int unsigned MEM_BYTE_ADDR_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [7:0]                     tx_data,
  output logic                           umem_ctrl,
  output logic                           umem_rd_en,
  output logic                           umem_wr_en,
  output logic [MEM_BYTE_ADDR_WIDTH-1:0] umem_addr,
  output logic [7:0]                     umem_wr_data,
  input  logic [7:0]                     umem_rd_data,
  output logic                           rx_overrun
);

  localparam int unsigned AW = MEM_BYTE_ADDR_WIDTH;

  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_LEN,
    WR_DATA,
    RD_LOAD,
    RD_WAIT,
    SEND_RESP
`ifdef UMEM_LOADER_CSUM_EN
    , SEND_CSUM
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            is_rd_q, is_rd_d;
  logic            tx_valid_d;
  logic [7:0]      tx_data_d;
  logic            ctrl_d;
  logic            rd_en_d;
  logic            wr_en_d;
  logic [AW-1:0]   addr_d;
  logic [7:0]      wr_data_d;
  logic            overrun_d;
  logic            hs;
  logic            drop_state;
`ifdef UMEM_LOADER_CSUM_EN
  logic [7:0]      csum_q, csum_d;
  logic            csum_cmd_q, csum_cmd_d;
`endif

  assign hs = tx_valid && tx_ready;

  // States in which the engine cannot accept an RX byte
  always_comb begin
    drop_state = 1'b0;
    case (state_q)
      RD_LOAD, RD_WAIT, SEND_RESP: drop_state = 1'b1;
`ifdef UMEM_LOADER_CSUM_EN
      SEND_CSUM:                   drop_state = 1'b1;
`endif
      default:                     drop_state = 1'b0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    is_rd_d    = is_rd_q;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    ctrl_d     = umem_ctrl;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    addr_d     = umem_addr;
    wr_data_d  = umem_wr_data;
    overrun_d  = rx_overrun || (rx_valid && drop_state);
`ifdef UMEM_LOADER_CSUM_EN
    csum_d     = csum_q;
    csum_cmd_d = csum_cmd_q;
`endif

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
`ifdef UMEM_LOADER_CSUM_EN
          csum_cmd_d = 1'b0;
`endif
          case (rx_data)
            CMD_H: begin
              ctrl_d     = 1'b1;
              tx_valid_d = 1'b1;
              tx_data_d  = ACK;
              state_d    = SEND_RESP;
            end
            CMD_G: begin
              ctrl_d     = 1'b0;
              tx_valid_d = 1'b1;
              tx_data_d  = ACK;
              state_d    = SEND_RESP;
            end
            CMD_W, CMD_R: begin
              if (umem_ctrl) begin
                is_rd_d = (rx_data == CMD_R);
                state_d = GET_ADDR;
              end else begin
                tx_valid_d = 1'b1;
                tx_data_d  = NAK;
                state_d    = SEND_RESP;
              end
            end
            default: begin
              tx_valid_d = 1'b1;
              tx_data_d  = NAK;
              state_d    = SEND_RESP;
            end
          endcase
        end
      end

      GET_ADDR: begin
        if (rx_valid) begin
          ptr_d   = rx_data[AW-1:0];
          state_d = GET_LEN;
        end
      end

      GET_LEN: begin
        if (rx_valid) begin
          cnt_d = rx_data;
`ifdef UMEM_LOADER_CSUM_EN
          csum_d     = 8'h00;
          csum_cmd_d = 1'b1;
`endif
          if (is_rd_q) begin
            addr_d  = ptr_q;
            rd_en_d = 1'b1;
            state_d = RD_LOAD;
          end else begin
            state_d = WR_DATA;
          end
        end
      end

      WR_DATA: begin
        if (rx_valid) begin
          wr_en_d   = 1'b1;
          addr_d    = ptr_q;
          wr_data_d = rx_data;
          ptr_d     = ptr_q + AW'(1);
`ifdef UMEM_LOADER_CSUM_EN
          csum_d    = csum_q ^ rx_data;
`endif
          if (cnt_q == 8'd0) begin
            tx_valid_d = 1'b1;
            tx_data_d  = ACK;
            state_d    = SEND_RESP;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end

      RD_LOAD: begin
        tx_data_d  = umem_rd_data;
        tx_valid_d = 1'b1;
`ifdef UMEM_LOADER_CSUM_EN
        csum_d     = csum_q ^ umem_rd_data;
`endif
        state_d    = RD_WAIT;
      end

      RD_WAIT: begin
        if (hs) begin
          ptr_d = ptr_q + AW'(1);
          if (cnt_q == 8'd0) begin
            // Response replaces the accepted data byte without a bubble
            tx_data_d = ACK;
            state_d   = SEND_RESP;
          end else begin
            cnt_d      = cnt_q - 8'd1;
            tx_valid_d = 1'b0;
            addr_d     = ptr_q + AW'(1);
            rd_en_d    = 1'b1;
            state_d    = RD_LOAD;
          end
        end
      end

      SEND_RESP: begin
        if (hs) begin
`ifdef UMEM_LOADER_CSUM_EN
          if (csum_cmd_q) begin
            tx_data_d = csum_q;
            state_d   = SEND_CSUM;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end
`else
          tx_valid_d = 1'b0;
          state_d    = IDLE;
`endif
        end
      end

`ifdef UMEM_LOADER_CSUM_EN
      SEND_CSUM: begin
        if (hs) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= 8'd0;
      is_rd_q      <= 1'b0;
      tx_valid     <= 1'b0;
      tx_data      <= 8'h00;
      umem_ctrl    <= 1'b1;
      umem_rd_en   <= 1'b0;
      umem_wr_en   <= 1'b0;
      umem_addr    <= '0;
      umem_wr_data <= 8'h00;
      rx_overrun   <= 1'b0;
`ifdef UMEM_LOADER_CSUM_EN
      csum_q       <= 8'h00;
      csum_cmd_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      is_rd_q      <= is_rd_d;
      tx_valid     <= tx_valid_d;
      tx_data      <= tx_data_d;
      umem_ctrl    <= ctrl_d;
      umem_rd_en   <= rd_en_d;
      umem_wr_en   <= wr_en_d;
      umem_addr    <= addr_d;
      umem_wr_data <= wr_data_d;
      rx_overrun   <= overrun_d;
`ifdef UMEM_LOADER_CSUM_EN
      csum_q       <= csum_d;
      csum_cmd_q   <= csum_cmd_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: transaction-level model of expected TX bytes and memory writes,
// checked every cycle by one monitor process, plus literal pins on key results.
module tb_uart_mem_loader;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;
  localparam int          BUDGET = 2000;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic          clk;
  logic          rst_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          umem_ctrl;
  logic          umem_rd_en;
  logic          umem_wr_en;
  logic [AW-1:0] umem_addr;
  logic [7:0]    umem_wr_data;
  logic [7:0]    umem_rd_data;
  logic          rx_overrun;

  uart_mem_loader #(.MEM_BYTE_ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .umem_ctrl    (umem_ctrl),
    .umem_rd_en   (umem_rd_en),
    .umem_wr_en   (umem_wr_en),
    .umem_addr    (umem_addr),
    .umem_wr_data (umem_wr_data),
    .umem_rd_data (umem_rd_data),
    .rx_overrun   (rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory the DUT drives (environment)
  logic [7:0] mem [DEPTH];
  always @(posedge clk) if (umem_wr_en) mem[umem_addr] <= umem_wr_data;
  assign umem_rd_data = mem[umem_addr];

  // Model state
  logic [7:0]    ref_mem [DEPTH];
  logic          m_ctrl;
  logic [7:0]    exp_tx[$];
  logic [AW-1:0] exp_wa[$];
  logic [7:0]    exp_wd[$];
  logic [7:0]    tx_log[$];
  logic [7:0]    payload[$];
  int            stall;
  int            checks;
  int            errors;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + TX sink: one pass per negedge
  initial begin
    int  wcnt;
    bit  prev_stall;
    logic [7:0] prev_data;
    wcnt = 0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_ready = 1'b0;
        wcnt = 0;
        prev_stall = 1'b0;
      end else begin
        chk("rd_wr_exclusive", int'(umem_rd_en & umem_wr_en), 0);
        if (prev_stall) begin
          chk("tx_hold_valid", int'(tx_valid), 1);
          chk("tx_hold_data", int'(tx_data), int'(prev_data));
        end
        if (umem_wr_en) begin
          chk("wr_expected", int'(exp_wa.size() > 0), 1);
          if (exp_wa.size() > 0) begin
            chk("wr_addr", int'(umem_addr), int'(exp_wa.pop_front()));
            chk("wr_data", int'(umem_wr_data), int'(exp_wd.pop_front()));
          end
        end
        if (tx_ready) begin
          tx_ready = 1'b0;
          wcnt = 0;
        end else if (tx_valid) begin
          if (wcnt >= stall) tx_ready = 1'b1;
          else wcnt++;
        end
        if (tx_valid && tx_ready) begin
          tx_log.push_back(tx_data);
          chk("tx_expected", int'(exp_tx.size() > 0), 1);
          if (exp_tx.size() > 0) chk("tx_data", int'(tx_data), int'(exp_tx.pop_front()));
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_tx.size() > 0 || exp_wa.size() > 0 || tx_valid) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_timeout"}, int'(n < BUDGET), 1);
  endtask

  // H/G: ownership flips and an ACK comes back
  task automatic cmd_hg(input logic [7:0] b);
    m_ctrl = (b == 8'h48);
    exp_tx.push_back(ACK);
    send(b);
  endtask

  // W of the bytes in payload starting at addr (expectations queued first)
  task automatic cmd_write(input logic [7:0] addr);
    logic [AW-1:0] p;
    logic [7:0]    cs;
    p  = addr[AW-1:0];
    cs = 8'h00;
    foreach (payload[i]) begin
      exp_wa.push_back(p);
      exp_wd.push_back(payload[i]);
      ref_mem[p] = payload[i];
      cs ^= payload[i];
      p = p + AW'(1);
    end
    exp_tx.push_back(ACK);
`ifdef UMEM_LOADER_CSUM_EN
    exp_tx.push_back(cs);
`endif
    send(8'h57);
    send(addr);
    send(8'(payload.size() - 1));
    foreach (payload[i]) send(payload[i]);
  endtask

  // R of len+1 bytes; optionally inject a stray RX byte while a data byte is stalled
  task automatic cmd_read(input logic [7:0] addr, input logic [7:0] len, input bit inject);
    logic [AW-1:0] p;
    logic [7:0]    cs;
    int            n;
    p  = addr[AW-1:0];
    cs = 8'h00;
    for (int i = 0; i <= int'(len); i++) begin
      exp_tx.push_back(ref_mem[p]);
      cs ^= ref_mem[p];
      p = p + AW'(1);
    end
    exp_tx.push_back(ACK);
`ifdef UMEM_LOADER_CSUM_EN
    exp_tx.push_back(cs);
`endif
    send(8'h52);
    send(addr);
    send(len);
    if (inject) begin
      n = 0;
      while (!(tx_valid && !tx_ready) && n < BUDGET) begin
        @(negedge clk);
        n++;
      end
      chk("inject_wait_timeout", int'(n < BUDGET), 1);
      send(8'h57);
    end
  endtask

  // Async reset asserted between edges, outputs checked before the next edge
  task automatic reset_pulse(input string name);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({name, "_umem_ctrl"}, int'(umem_ctrl), 1);
    chk({name, "_tx_valid"}, int'(tx_valid), 0);
    chk({name, "_tx_data"}, int'(tx_data), 0);
    chk({name, "_wr_en"}, int'(umem_wr_en), 0);
    chk({name, "_rd_en"}, int'(umem_rd_en), 0);
    chk({name, "_addr"}, int'(umem_addr), 0);
    chk({name, "_wr_data"}, int'(umem_wr_data), 0);
    chk({name, "_rx_overrun"}, int'(rx_overrun), 0);
    exp_tx.delete();
    exp_wa.delete();
    exp_wd.delete();
    m_ctrl = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    checks   = 0;
    errors   = 0;
    stall    = 0;
    m_ctrl   = 1'b1;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("por_umem_ctrl", int'(umem_ctrl), 1);
    chk("por_tx_valid", int'(tx_valid), 0);
    chk("por_rx_overrun", int'(rx_overrun), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // W 0x44 (ptr 4) LEN 2
    payload = '{8'h11, 8'h22, 8'h33};
    tx_log.delete();
    cmd_write(8'h44);
    drain("write3");
    chk("pin_mem4", int'(mem[4]), 8'h11);
    chk("pin_mem5", int'(mem[5]), 8'h22);
    chk("pin_mem6", int'(mem[6]), 8'h33);
    chk("pin_write_ack", int'(tx_log[0]), 8'h06);

    // Seed mem[63]=AA, mem[0]=BB (write wraps), then stalled read across the wrap
    payload = '{8'hAA, 8'hBB};
    cmd_write(8'h3F);
    drain("seed");
    stall = 5;
    tx_log.delete();
    cmd_read(8'h3F, 8'h01, 1'b0);
    drain("read_wrap");
    stall = 0;
    chk("pin_rd0", int'(tx_log[0]), 8'hAA);
    chk("pin_rd1", int'(tx_log[1]), 8'hBB);
    chk("pin_rd_ack", int'(tx_log[2]), 8'h06);
`ifdef UMEM_LOADER_CSUM_EN
    chk("pin_rd_csum", int'(tx_log[3]), 8'h11);
    chk("pin_rd_len", tx_log.size(), 4);
`else
    chk("pin_rd_len", tx_log.size(), 3);
`endif
    chk("no_overrun_yet", int'(rx_overrun), 0);

    // Ownership: G, W refused, H, unknown byte
    tx_log.delete();
    cmd_hg(8'h47);
    drain("go");
    chk("ctrl_after_g", int'(umem_ctrl), int'(m_ctrl));
    exp_tx.push_back(NAK);
    send(8'h57);
    drain("w_refused");
    cmd_hg(8'h48);
    drain("halt");
    chk("ctrl_after_h", int'(umem_ctrl), int'(m_ctrl));
    exp_tx.push_back(NAK);
    send(8'h00);
    drain("unknown");
    chk("pin_hg_log0", int'(tx_log[0]), 8'h06);
    chk("pin_hg_log1", int'(tx_log[1]), 8'h15);
    chk("pin_hg_log2", int'(tx_log[2]), 8'h06);
    chk("pin_hg_log3", int'(tx_log[3]), 8'h15);

    // Reset while the CPU owns memory
    cmd_hg(8'h47);
    drain("go2");
    chk("ctrl_before_reset", int'(umem_ctrl), 0);
    reset_pulse("idle_reset");
    repeat (2) @(negedge clk);

    // Stray byte during a stalled read burst
    stall = 5;
    cmd_read(8'h04, 8'h02, 1'b1);
    drain("read_overrun");
    stall = 0;
    chk("rx_overrun_set", int'(rx_overrun), 1);
    cmd_hg(8'h48);
    drain("after_overrun");
    chk("rx_overrun_sticky", int'(rx_overrun), 1);

    // Reset after the first data byte of a 4-byte write
    exp_wa.push_back(AW'(6'h10));
    exp_wd.push_back(8'h5A);
    ref_mem[16] = 8'h5A;
    send(8'h57);
    send(8'h10);
    send(8'h03);
    send(8'h5A);
    n = 0;
    while (exp_wa.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("partial_write_seen", int'(exp_wa.size()), 0);
    reset_pulse("burst_reset");
    chk("partial_write_kept", int'(mem[16]), 8'h5A);
    tx_log.delete();
    cmd_hg(8'h48);
    drain("post_reset_h");
    chk("pin_post_reset_ack", int'(tx_log.size() > 0 ? tx_log[0] : 8'h00), 8'h06);
    chk("final_ctrl", int'(umem_ctrl), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
